// File: rtl/comp_pkg.sv
// -----------------------------------------------------------------------------
// comp_pkg
// Shared types and helpers for the comparator result monitor.
//   cmp_res_t   : 2-bit code of a comparator outcome (NONE/ST/EQ/LT)
//   mon_state_t : states of the match-lock / fault FSM
//   chk_t       : result of the one-hot flag check (legal bit + decoded code)
//   onehot_chk  : decodes {ST,EQ,LT} into a chk_t
// -----------------------------------------------------------------------------
package comp_pkg;

  typedef enum logic [1:0] {
    CMP_NONE = 2'b00,
    CMP_ST   = 2'b01,
    CMP_EQ   = 2'b10,
    CMP_LT   = 2'b11
  } cmp_res_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_HUNT  = 2'b01,
    S_LOCK  = 2'b10,
    S_FAULT = 2'b11
  } mon_state_t;

  typedef struct packed {
    logic     legal;
    cmp_res_t res;
  } chk_t;

  // Exactly one flag set is legal; zero-hot or multi-hot is reported as illegal
  // with a NONE code so callers never act on a bogus outcome.
  function automatic chk_t onehot_chk(input logic st, input logic eq, input logic lt);
    chk_t c;
    c.legal = 1'b1;
    c.res   = CMP_NONE;
    case ({st, eq, lt})
      3'b100:  c.res = CMP_ST;
      3'b010:  c.res = CMP_EQ;
      3'b001:  c.res = CMP_LT;
      default: c.legal = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/comp_monitor_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   CLK   : clock, rising edge
//   RST_N : asynchronous active-low reset, clears Q
//   CLR   : synchronous clear, has priority over INC
//   INC   : add one this cycle (ignored once saturated)
//   Q     : registered count, W bits
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         CLR,
  input  logic         INC,
  output logic [W-1:0] Q
);

  logic [W-1:0] r_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_q <= '0;
    end else if (CLR) begin
      r_q <= '0;
    end else if (INC && (r_q != {W{1'b1}})) begin
      r_q <= r_q + W'(1);
    end
  end

  assign Q = r_q;

endmodule

// File: rtl/comp_monitor.sv
// -----------------------------------------------------------------------------
// comp_monitor
// Watches the one-hot result flags of the 4-bit magnitude comparator. Keeps
// saturating per-outcome counts, the code of the last legal outcome, a
// "match lock" indication after RUN_LEN consecutive EQ samples, and a sticky
// fault for illegal flag combinations.
// Ports:
//   CLK, RST_N  : clock (rising edge), asynchronous active-low reset
//   VALID       : flags below are meaningful this cycle
//   ST, EQ, LT  : comparator flags (A<B, A==B, A>B)
//   CLR         : synchronous clear of all state, beats VALID
//   ST_CNT, EQ_CNT, LT_CNT : saturating outcome counts (CNT_W bits)
//   LAST        : code of last legal sample (00 none, 01 ST, 10 EQ, 11 LT)
//   MATCH_LOCK  : FSM is in S_LOCK
//   ERR         : FSM is in S_FAULT
// All outputs are registered; there is no input-to-output combinational path.
// -----------------------------------------------------------------------------
module comp_monitor
  import comp_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int RUN_LEN = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             VALID,
  input  logic             ST,
  input  logic             EQ,
  input  logic             LT,
  input  logic             CLR,
  output logic [CNT_W-1:0] ST_CNT,
  output logic [CNT_W-1:0] EQ_CNT,
  output logic [CNT_W-1:0] LT_CNT,
  output logic [1:0]       LAST,
  output logic             MATCH_LOCK,
  output logic             ERR
);

  localparam int               RUN_W   = $clog2(RUN_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);

  mon_state_t       r_state;
  logic [RUN_W-1:0] r_run_cnt;
  cmp_res_t         r_last;
  logic             r_match_lock;
  logic             r_err;

  chk_t             w_chk;
  logic             w_accept;
  logic [2:0]       w_inc;
  logic [CNT_W-1:0] w_cnt [3];

  assign w_chk = onehot_chk(ST, EQ, LT);

  // A sample is counted only when legal, not discarded by CLR, and the
  // monitor is not frozen in fault.
  assign w_accept = VALID && w_chk.legal && !CLR && (r_state != S_FAULT);

  // Counter index 0: ST, 1: EQ, 2: LT.
  assign w_inc[0] = w_accept && (w_chk.res == CMP_ST);
  assign w_inc[1] = w_accept && (w_chk.res == CMP_EQ);
  assign w_inc[2] = w_accept && (w_chk.res == CMP_LT);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      sat_counter #(
        .W(CNT_W)
      ) u_cnt (
        .CLK  (CLK),
        .RST_N(RST_N),
        .CLR  (CLR),
        .INC  (w_inc[gi]),
        .Q    (w_cnt[gi])
      );
    end
  endgenerate

  // Match-lock / fault FSM with registered flag outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_run_cnt    <= '0;
      r_last       <= CMP_NONE;
      r_match_lock <= 1'b0;
      r_err        <= 1'b0;
    end else if (CLR) begin
      r_state      <= S_IDLE;
      r_run_cnt    <= '0;
      r_last       <= CMP_NONE;
      r_match_lock <= 1'b0;
      r_err        <= 1'b0;
    end else if (VALID) begin
      if (!w_chk.legal) begin
        r_state      <= S_FAULT;
        r_match_lock <= 1'b0;
        r_err        <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE, S_HUNT: begin
            r_last <= w_chk.res;
            if (w_chk.res == CMP_EQ) begin
              // run_cnt < RUN_LEN here, so this sample completes the run
              // exactly when run_cnt is one short of RUN_LEN.
              if (r_run_cnt >= (RUN_MAX - RUN_W'(1))) begin
                r_state      <= S_LOCK;
                r_run_cnt    <= RUN_MAX;
                r_match_lock <= 1'b1;
              end else begin
                r_state      <= S_HUNT;
                r_run_cnt    <= r_run_cnt + RUN_W'(1);
                r_match_lock <= 1'b0;
              end
            end else begin
              r_state      <= S_HUNT;
              r_run_cnt    <= '0;
              r_match_lock <= 1'b0;
            end
          end
          S_LOCK: begin
            r_last <= w_chk.res;
            if (w_chk.res == CMP_EQ) begin
              r_run_cnt    <= RUN_MAX;
              r_match_lock <= 1'b1;
            end else begin
              r_state      <= S_HUNT;
              r_run_cnt    <= '0;
              r_match_lock <= 1'b0;
            end
          end
          default: begin
            // S_FAULT: legal samples are ignored until CLR or reset.
            r_state <= S_FAULT;
          end
        endcase
      end
    end
  end

  assign ST_CNT     = w_cnt[0];
  assign EQ_CNT     = w_cnt[1];
  assign LT_CNT     = w_cnt[2];
  assign LAST       = r_last;
  assign MATCH_LOCK = r_match_lock;
  assign ERR        = r_err;

endmodule

// File: tb/tb_comp_monitor.sv
// -----------------------------------------------------------------------------
// tb_comp_monitor
// Two instances: u_a (CNT_W=8, RUN_LEN=3) and u_b (CNT_W=2, RUN_LEN=1).
// The driver applies one directed sample per cycle and queues the hand-computed
// output values expected after the next edge; a monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_comp_monitor;

  logic clk;
  logic rst_n;

  logic       a_valid, a_st, a_eq, a_lt, a_clr;
  logic [7:0] a_st_cnt, a_eq_cnt, a_lt_cnt;
  logic [1:0] a_last;
  logic       a_lock, a_err;

  logic       b_valid, b_st, b_eq, b_lt, b_clr;
  logic [1:0] b_st_cnt, b_eq_cnt, b_lt_cnt;
  logic [1:0] b_last;
  logic       b_lock, b_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int dut;
    int st;
    int eq;
    int lt;
    int last;
    int lock;
    int err;
  } exp_t;

  exp_t exp_q[$];

  comp_monitor #(.CNT_W(8), .RUN_LEN(3)) u_a (
    .CLK       (clk),
    .RST_N     (rst_n),
    .VALID     (a_valid),
    .ST        (a_st),
    .EQ        (a_eq),
    .LT        (a_lt),
    .CLR       (a_clr),
    .ST_CNT    (a_st_cnt),
    .EQ_CNT    (a_eq_cnt),
    .LT_CNT    (a_lt_cnt),
    .LAST      (a_last),
    .MATCH_LOCK(a_lock),
    .ERR       (a_err)
  );

  comp_monitor #(.CNT_W(2), .RUN_LEN(1)) u_b (
    .CLK       (clk),
    .RST_N     (rst_n),
    .VALID     (b_valid),
    .ST        (b_st),
    .EQ        (b_eq),
    .LT        (b_lt),
    .CLR       (b_clr),
    .ST_CNT    (b_st_cnt),
    .EQ_CNT    (b_eq_cnt),
    .LT_CNT    (b_lt_cnt),
    .LAST      (b_last),
    .MATCH_LOCK(b_lock),
    .ERR       (b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // One sample on the chosen instance; the other instance idles.
  task automatic step(input int dut, input logic v, input logic s, input logic e,
                      input logic l, input logic c, input int est, input int eeq,
                      input int elt, input int elast, input int elock, input int eerr);
    exp_t x;
    @(negedge clk);
    a_valid = 1'b0; a_clr = 1'b0;
    b_valid = 1'b0; b_clr = 1'b0;
    if (dut == 0) begin
      a_valid = v; a_st = s; a_eq = e; a_lt = l; a_clr = c;
    end else begin
      b_valid = v; b_st = s; b_eq = e; b_lt = l; b_clr = c;
    end
    x.dut = dut; x.st = est; x.eq = eeq; x.lt = elt;
    x.last = elast; x.lock = elock; x.err = eerr;
    exp_q.push_back(x);
  endtask

  // Monitor: compare shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.dut == 0) begin
          check("a_st_cnt", int'(a_st_cnt), e.st);
          check("a_eq_cnt", int'(a_eq_cnt), e.eq);
          check("a_lt_cnt", int'(a_lt_cnt), e.lt);
          check("a_last",   int'(a_last),   e.last);
          check("a_lock",   int'(a_lock),   e.lock);
          check("a_err",    int'(a_err),    e.err);
          $display("txn dut=a cnt=%0d/%0d/%0d last=%0d lock=%0d err=%0d",
                   a_st_cnt, a_eq_cnt, a_lt_cnt, a_last, a_lock, a_err);
        end else begin
          check("b_st_cnt", int'(b_st_cnt), e.st);
          check("b_eq_cnt", int'(b_eq_cnt), e.eq);
          check("b_lt_cnt", int'(b_lt_cnt), e.lt);
          check("b_last",   int'(b_last),   e.last);
          check("b_lock",   int'(b_lock),   e.lock);
          check("b_err",    int'(b_err),    e.err);
          $display("txn dut=b cnt=%0d/%0d/%0d last=%0d lock=%0d err=%0d",
                   b_st_cnt, b_eq_cnt, b_lt_cnt, b_last, b_lock, b_err);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_st = 1'b0; a_eq = 1'b0; a_lt = 1'b0; a_clr = 1'b0;
    b_valid = 1'b0; b_st = 1'b0; b_eq = 1'b0; b_lt = 1'b0; b_clr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_a_st_cnt", int'(a_st_cnt), 0);
    check("rst_a_eq_cnt", int'(a_eq_cnt), 0);
    check("rst_a_lt_cnt", int'(a_lt_cnt), 0);
    check("rst_a_last",   int'(a_last),   0);
    check("rst_a_lock",   int'(a_lock),   0);
    check("rst_a_err",    int'(a_err),    0);
    $display("txn reset state checked");
    @(negedge clk);
    rst_n = 1'b1;

    // Pairs (1,1),(5,1),(0,3),(1,8),(1,0),(8,1): EQ,LT,ST,ST,LT,LT
    step(0, 1, 0, 1, 0, 0,  0, 1, 0, 2, 0, 0);
    step(0, 1, 0, 0, 1, 0,  0, 1, 1, 3, 0, 0);
    step(0, 1, 1, 0, 0, 0,  1, 1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0, 0,  2, 1, 1, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0,  2, 1, 2, 3, 0, 0);
    step(0, 1, 0, 0, 1, 0,  2, 1, 3, 3, 0, 0);
    // Three EQ lock on the third; LT breaks it; two EQ do not relock
    step(0, 1, 0, 1, 0, 0,  2, 2, 3, 2, 0, 0);
    step(0, 1, 0, 1, 0, 0,  2, 3, 3, 2, 0, 0);
    step(0, 1, 0, 1, 0, 0,  2, 4, 3, 2, 1, 0);
    step(0, 1, 0, 0, 1, 0,  2, 4, 4, 3, 0, 0);
    step(0, 1, 0, 1, 0, 0,  2, 5, 4, 2, 0, 0);
    step(0, 1, 0, 1, 0, 0,  2, 6, 4, 2, 0, 0);
    // Third EQ of the new run locks, a further EQ holds the lock
    step(0, 1, 0, 1, 0, 0,  2, 7, 4, 2, 1, 0);
    step(0, 1, 0, 1, 0, 0,  2, 8, 4, 2, 1, 0);

    // Narrow counters saturate at 3; RUN_LEN=1 locks on a single EQ
    step(1, 1, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0, 0,  2, 0, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0, 0,  3, 0, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0, 0,  3, 0, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0, 0,  3, 0, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0,  3, 1, 0, 2, 1, 0);
    step(1, 1, 0, 0, 1, 0,  3, 1, 1, 3, 0, 0);
    step(1, 1, 0, 1, 0, 0,  3, 2, 1, 2, 1, 0);

    // Multi-hot faults; legal EQ and zero-hot in fault change nothing; CLR recovers
    step(0, 1, 1, 1, 0, 0,  2, 8, 4, 2, 0, 1);
    step(0, 1, 0, 1, 0, 0,  2, 8, 4, 2, 0, 1);
    step(0, 1, 0, 0, 0, 0,  2, 8, 4, 2, 0, 1);
    step(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    // Zero-hot from a healthy state also faults
    step(0, 1, 0, 1, 0, 0,  0, 1, 0, 2, 0, 0);
    step(0, 1, 0, 0, 0, 0,  0, 1, 0, 2, 0, 1);
    step(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);

    // CLR beats a same-cycle legal EQ
    step(0, 1, 0, 1, 0, 0,  0, 1, 0, 2, 0, 0);
    step(0, 1, 1, 0, 0, 0,  1, 1, 0, 1, 0, 0);
    step(0, 1, 0, 1, 0, 1,  0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0);
    // VALID=0 with random flags leaves everything alone
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 0,  1, 0, 0, 1, 0, 0);
    end
    // Build a lock with EQ_CNT=4
    step(0, 1, 0, 1, 0, 0,  1, 1, 0, 2, 0, 0);
    step(0, 1, 0, 1, 0, 0,  1, 2, 0, 2, 0, 0);
    step(0, 1, 0, 1, 0, 0,  1, 3, 0, 2, 1, 0);
    step(0, 1, 0, 1, 0, 0,  1, 4, 0, 2, 1, 0);

    // Drain the scoreboard within a bounded number of cycles
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 0);

    // Asynchronous reset between edges while locked
    check("pre_rst_a_lock", int'(a_lock), 1);
    check("pre_rst_a_eq_cnt", int'(a_eq_cnt), 4);
    rst_n = 1'b0;
    #1;
    check("async_a_st_cnt", int'(a_st_cnt), 0);
    check("async_a_eq_cnt", int'(a_eq_cnt), 0);
    check("async_a_lt_cnt", int'(a_lt_cnt), 0);
    check("async_a_last",   int'(a_last),   0);
    check("async_a_lock",   int'(a_lock),   0);
    check("async_a_err",    int'(a_err),    0);
    check("async_b_st_cnt", int'(b_st_cnt), 0);
    check("async_b_lock",   int'(b_lock),   0);
    $display("txn async reset checked");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comp_monitor.md
# comp_monitor

Sequential stage directly downstream of the 4-bit magnitude comparator. It samples the comparator's one-hot result flags (ST: A<B, EQ: A==B, LT: A>B) on a qualifying strobe. It keeps saturating per-outcome event counts and detects runs of consecutive equal results ("match lock"). It also flags illegal flag combinations as a sticky fault.

## Interface
Parameters:
- CNT_W, 8: width of each outcome counter.
- RUN_LEN, 3: number of consecutive valid EQ samples required to assert MATCH_LOCK. Legal range is ≥1.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  reset; asynchronous, active-low.
- VALID  input  1  a comparator result is present this cycle.
- ST  input  1  comparator flag, A<B.
- EQ  input  1  comparator flag, A==B.
- LT  input  1  comparator flag, A>B.
- CLR  input  1  synchronous clear of counters, run state and fault.
- ST_CNT  output  CNT_W  saturating count of valid ST samples.
- EQ_CNT  output  CNT_W  saturating count of valid EQ samples.
- LT_CNT  output  CNT_W  saturating count of valid LT samples.
- LAST  output  2  code of the last legal sample: NONE=00, ST=01, EQ=10, LT=11.
- MATCH_LOCK  output  1  RUN_LEN or more consecutive valid EQ samples seen.
- ERR  output  1  sticky illegal-flag fault.

## Operation
- A sample is legal when VALID=1 and {ST,EQ,LT} is exactly one-hot. A sample is illegal when VALID=1 and the flags are zero-hot or multi-hot.
- When VALID=0, the flags are ignored and no state changes.
- FSM states:
  - S_IDLE: no legal sample since reset or CLR.
  - S_HUNT: counting the EQ run.
  - S_LOCK: the EQ run has reached RUN_LEN.
  - S_FAULT: an illegal sample has been seen.
- Transitions:
  - From IDLE or HUNT: a legal EQ increments run_cnt. When run_cnt reaches RUN_LEN, go to LOCK, else go to or stay in HUNT.
  - From IDLE or HUNT: a legal ST or LT clears run_cnt and goes to HUNT.
  - In LOCK: a legal EQ stays in LOCK, with run_cnt held at RUN_LEN. A legal ST or LT clears run_cnt and goes to HUNT.
  - From any state: an illegal sample goes to FAULT.
  - FAULT is left only by CLR or reset, both of which go to IDLE.
- Counters:
  - A legal sample increments the matching counter by 1.
  - Counters saturate at 2^CNT_W−1 and never wrap.
  - Counters and LAST freeze while in FAULT.
- Outputs:
  - MATCH_LOCK = (state == S_LOCK).
  - ERR = (state == S_FAULT).
  - LAST updates only on legal samples.
- CLR has priority over VALID in the same cycle; that sample is discarded.
- RUN_LEN=1: a single legal EQ locks.

## Timing
- All outputs are registered. A sample presented before rising edge k is reflected on the outputs immediately after edge k (1-cycle latency). There is no combinational input-to-output path.
- Back-to-back samples are accepted every cycle. There is no backpressure.
- Reset values: all counters 0, LAST=00, MATCH_LOCK=0, ERR=0, state=S_IDLE, run_cnt=0.
- RST_N assertion mid-run or mid-lock clears everything asynchronously, without waiting for a clock edge. Deassertion is assumed synchronised upstream, and the first sample is accepted on the first edge after deassertion.
- CLR takes effect at the edge: the outputs show reset values in the following cycle.
- A counter at saturation receiving another legal sample stays at 2^CNT_W−1. The other counters and the FSM still update normally.

## Structure
- Package comp_pkg holds:
  - cmp_res_t: 2-bit enum NONE/ST/EQ/LT.
  - mon_state_t: enum S_IDLE/S_HUNT/S_LOCK/S_FAULT.
  - A one-hot-check function returning cmp_res_t or an illegal indication.
- Sub-module sat_counter (parameter W; ports CLK, RST_N, CLR, INC, Q) is instantiated three times.
- The FSM and run_cnt, width $clog2(RUN_LEN+1), live in comp_monitor.

## Test plan
- Reset, then legal samples for the pairs (1,1),(5,1),(0,3),(1,8),(1,0),(8,1), giving EQ,LT,ST,ST,LT,LT → ST_CNT=2, EQ_CNT=1, LT_CNT=3, LAST=11, MATCH_LOCK=0, ERR=0.
- RUN_LEN=3: EQ,EQ,EQ → MATCH_LOCK=1 one cycle after the third sample. Then one LT → MATCH_LOCK=0 next cycle. Then EQ,EQ → MATCH_LOCK stays 0.
- CNT_W=2: five consecutive ST → ST_CNT reads 1,2,3,3,3, and no other counter changes.
- VALID=1 with ST=1,EQ=1 → ERR=1 next cycle. A following legal EQ leaves EQ_CNT unchanged. CLR → ERR=0, all counters 0, LAST=00.
- CLR and a legal EQ in the same cycle → EQ_CNT=0 next cycle. VALID=0 with random flags for 10 cycles → no output changes.
- While MATCH_LOCK=1 with EQ_CNT=4, drive RST_N low between clock edges → all outputs are 0 before the next edge.
